// File: rtl/fsm_cond_pkg.sv
// fsm_cond_pkg: shared symbol type, conditioner state encoding and idle symbol.
`default_nettype none

package fsm_cond_pkg;

    typedef logic [1:0] symbol_t;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_TRACK  = 1'b1
    } cond_state_t;

    localparam symbol_t SYM_IDLE = 2'b00;

endpackage

`default_nettype wire

// File: rtl/fsm_input_conditioner_sync.sv
// sync_chain: per-bit multi-flop synchroniser with asynchronous reset to RST_VAL.
`default_nettype none

module sync_chain #(
    parameter int               WIDTH   = 2,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stages[i] <= RST_VAL;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fsm_input_conditioner.sv
// fsm_input_conditioner: synchronises and debounces a 2-bit raw symbol for the
// downstream control FSMs, flagging accepted changes and counting rejected candidates.
`default_nettype none

module fsm_input_conditioner
    import fsm_cond_pkg::*;
#(
    parameter int      SYNC_STAGES     = 2,
    parameter int      DEBOUNCE_CYCLES = 4,
    parameter symbol_t RESET_SYMBOL    = SYM_IDLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] raw_in,
    input  logic       enable,
    output logic [1:0] sym_out,
    output logic       sym_valid,
    output logic       sym_change,
    output logic [7:0] glitch_cnt
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    symbol_t       sync;
    symbol_t       cand;
    logic [CW-1:0] cnt;
    cond_state_t   state;

    sync_chain #(
        .WIDTH   (2),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RESET_SYMBOL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_STABLE;
            cand       <= RESET_SYMBOL;
            cnt        <= '0;
            sym_out    <= RESET_SYMBOL;
            sym_valid  <= 1'b1;
            sym_change <= 1'b0;
            glitch_cnt <= 8'h00;
        end else begin
            sym_change <= 1'b0;
            if (!enable) begin
                // Disabling abandons any pending candidate without counting it as a glitch.
                state     <= ST_STABLE;
                cnt       <= '0;
                sym_valid <= 1'b1;
            end else begin
                case (state)
                    ST_STABLE: begin
                        if (sync != sym_out) begin
                            state     <= ST_TRACK;
                            cand      <= sync;
                            cnt       <= CW'(1);
                            sym_valid <= 1'b0;
                        end
                    end
                    ST_TRACK: begin
                        if (sync == cand) begin
                            if (cnt == CNT_LAST) begin
                                sym_out    <= cand;
                                sym_change <= 1'b1;
                                cnt        <= '0;
                                state      <= ST_STABLE;
                                sym_valid  <= 1'b1;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else begin
                            if (glitch_cnt != 8'hFF) begin
                                glitch_cnt <= glitch_cnt + 8'd1;
                            end
                            if (sync == sym_out) begin
                                state     <= ST_STABLE;
                                cnt       <= '0;
                                sym_valid <= 1'b1;
                            end else begin
                                cand <= sync;
                                cnt  <= CW'(1);
                            end
                        end
                    end
                    default: begin
                        state     <= ST_STABLE;
                        cnt       <= '0;
                        sym_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fsm_input_conditioner.sv
// tb_fsm_input_conditioner: directed scenarios plus randomized stimulus against a
// run-length reference model of the debounced symbol.
`default_nettype none

module tb_fsm_input_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] raw_in;
    logic       enable;
    logic [1:0] sym_out;
    logic       sym_valid;
    logic       sym_change;
    logic [7:0] glitch_cnt;

    int checks   = 0;
    int failures = 0;

    fsm_input_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .RESET_SYMBOL    (2'b00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .enable     (enable),
        .sym_out    (sym_out),
        .sym_valid  (sym_valid),
        .sym_change (sym_change),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a symbol is accepted once the synchronised value has differed
    // from the current output and held one value for DEB consecutive enabled samples.
    logic [1:0] m_pipe[$];
    logic [1:0] m_out;
    logic [1:0] m_val;
    int         m_run;
    int         m_glitch;
    logic       m_change;

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < SYNC; i++) m_pipe.push_back(2'b00);
        m_out = 2'b00; m_val = 2'b00; m_run = 0; m_glitch = 0; m_change = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] r, input logic e);
        logic [1:0] s;
        s = m_pipe[SYNC-1];
        m_pipe.push_front(r);
        void'(m_pipe.pop_back());
        m_change = 1'b0;
        if (!e) begin
            m_run = 0;
        end else if (s == m_out) begin
            if (m_run > 0 && m_glitch < 255) m_glitch++;
            m_run = 0;
        end else if (m_run > 0 && s == m_val) begin
            m_run++;
            if (m_run == DEB) begin
                m_out = s; m_change = 1'b1; m_run = 0;
            end
        end else begin
            if (m_run > 0 && m_glitch < 255) m_glitch++;
            m_val = s; m_run = 1;
        end
    endtask

    task automatic step(input logic [1:0] r, input logic e);
        raw_in = r;
        enable = e;
        @(posedge clk);
        model_edge(r, e);
        #1;
    endtask

    task automatic apply_reset();
        raw_in = 2'b00;
        enable = 1'b1;
        reset  = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(2'b00, 1'b1);
            checks++;
            if (sym_out !== 2'b00 || sym_valid !== 1'b1 || sym_change !== 1'b0 || glitch_cnt !== 8'h00) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got out=%b valid=%b chg=%b gl=%0d want out=00 valid=1 chg=0 gl=0",
                         i, sym_out, sym_valid, sym_change, glitch_cnt);
            end
        end
    endtask

    task automatic test_accept();
        apply_reset();
        for (int i = 1; i <= 7; i++) begin
            step(2'b10, 1'b1);
            checks++;
            if (sym_out !== ((i >= 6) ? 2'b10 : 2'b00) || sym_change !== (i == 6) ||
                sym_valid !== !(i >= 3 && i <= 5)) begin
                failures++;
                $display("FAIL accept edge=%0d got out=%b chg=%b valid=%b want out=%b chg=%b valid=%b",
                         i, sym_out, sym_change, sym_valid, (i >= 6) ? 2'b10 : 2'b00,
                         (i == 6), !(i >= 3 && i <= 5));
            end
        end
    endtask

    task automatic test_glitch();
        int changes = 0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step((i < 2) ? 2'b01 : 2'b00, 1'b1);
            if (sym_change) changes++;
            checks++;
            if (sym_out !== 2'b00) begin
                failures++;
                $display("FAIL glitch_hold cyc=%0d got out=%b want 00", i, sym_out);
            end
        end
        checks++;
        if (glitch_cnt !== 8'd1 || changes != 0) begin
            failures++;
            $display("FAIL glitch_count got gl=%0d changes=%0d want gl=1 changes=0", glitch_cnt, changes);
        end
    endtask

    task automatic test_restart();
        apply_reset();
        for (int i = 1; i <= 9; i++) begin
            step((i <= 2) ? 2'b01 : 2'b11, 1'b1);
            checks++;
            if (sym_out !== ((i >= 8) ? 2'b11 : 2'b00) || sym_change !== (i == 8)) begin
                failures++;
                $display("FAIL restart edge=%0d got out=%b chg=%b want out=%b chg=%b",
                         i, sym_out, sym_change, (i >= 8) ? 2'b11 : 2'b00, (i == 8));
            end
        end
        checks++;
        if (glitch_cnt !== 8'd1) begin
            failures++;
            $display("FAIL restart_glitch got gl=%0d want 1", glitch_cnt);
        end
    endtask

    task automatic test_enable();
        apply_reset();
        for (int i = 0; i < 10; i++) step(2'b11, 1'b0);
        checks++;
        if (sym_out !== 2'b00 || sym_valid !== 1'b1) begin
            failures++;
            $display("FAIL enable_frozen got out=%b valid=%b want out=00 valid=1", sym_out, sym_valid);
        end
        for (int i = 1; i <= 4; i++) begin
            step(2'b11, 1'b1);
            checks++;
            if (sym_out !== ((i == 4) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL enable_resume edge=%0d got out=%b want %b", i, sym_out,
                         (i == 4) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_reset_mid_track();
        apply_reset();
        for (int i = 0; i < 8; i++) step(2'b11, 1'b1);
        for (int i = 0; i < 4; i++) step(2'b10, 1'b1);
        checks++;
        if (sym_out !== 2'b11 || sym_valid !== 1'b0 || m_run != 2) begin
            failures++;
            $display("FAIL midtrack_setup got out=%b valid=%b want out=11 valid=0", sym_out, sym_valid);
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (sym_out !== 2'b00 || sym_valid !== 1'b1 || sym_change !== 1'b0 || glitch_cnt !== 8'h00) begin
            failures++;
            $display("FAIL midtrack_reset got out=%b valid=%b chg=%b gl=%0d want out=00 valid=1 chg=0 gl=0",
                     sym_out, sym_valid, sym_change, glitch_cnt);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 6; i++) step(2'b00, 1'b1);
        checks++;
        if (sym_out !== 2'b00 || sym_change !== 1'b0) begin
            failures++;
            $display("FAIL midtrack_after got out=%b chg=%b want out=00 chg=0", sym_out, sym_change);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 320; i++) step((i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
        checks++;
        if (glitch_cnt !== 8'hFF || sym_out !== 2'b00) begin
            failures++;
            $display("FAIL saturate got gl=%0d out=%b want gl=255 out=00", glitch_cnt, sym_out);
        end
    endtask

    task automatic test_random();
        logic [1:0] r;
        logic       e;
        apply_reset();
        r = 2'b00;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) r = 2'($urandom_range(3));
            e = ($urandom_range(9) != 0);
            step(r, e);
            checks++;
            if (sym_out !== m_out || sym_valid !== (m_run == 0) || sym_change !== m_change ||
                glitch_cnt !== 8'(m_glitch)) begin
                failures++;
                $display("FAIL random cyc=%0d got out=%b valid=%b chg=%b gl=%0d want out=%b valid=%b chg=%b gl=%0d",
                         i, sym_out, sym_valid, sym_change, glitch_cnt, m_out, (m_run == 0), m_change, m_glitch);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        raw_in = 2'b00;
        enable = 1'b1;
        model_reset();
        test_reset();
        test_accept();
        test_glitch();
        test_restart();
        test_enable();
        test_reset_mid_track();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
